// File: rtl/cache_fetch_pkg.sv
// cache_fetch_pkg: shared state encoding and address helpers for the line fetch controller
package cache_fetch_pkg;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, DONE} fetch_state_t;
  localparam int ADDR_W = 32;
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] tag, input logic [ADDR_W-1:0] idx, input int idx_w, input int off_w);
    return ((tag << idx_w) | idx) << off_w;
  endfunction
endpackage

// File: rtl/way_tag_mux.sv
// way_tag_mux: picks one way's tag out of the packed per-set tag bus
module way_tag_mux #(
  parameter int WAYS  = 2,
  parameter int TAG_W = 24,
  parameter int WW    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [WAYS*TAG_W-1:0] tags,
  input  logic [WW-1:0]         sel,
  output logic [TAG_W-1:0]      tag
);
  assign tag = tags[sel*TAG_W +: TAG_W];
endmodule

// File: rtl/cache_line_fetch.sv
// cache_line_fetch: memory-side miss handler; writes back a dirty victim, then fills the missing line
module cache_line_fetch
  import cache_fetch_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int TAG_W = 24,
  parameter int IDX_W = 3,
  parameter int OFF_W = 5,
  parameter int CNT_W = 16,
  parameter int WW    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_req,
  input  logic [ADDR_W-1:0]     mem_address,
  input  logic [WW-1:0]         victim_way,
  input  logic                  victim_dirty,
  input  logic [WAYS*TAG_W-1:0] tags,
  input  logic                  pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_W-1:0]     pmem_address,
  output logic                  busy,
  output logic                  load_line,
  output logic                  clear_dirty,
  output logic                  fill_done,
  output logic [CNT_W-1:0]      miss_count,
  output logic [CNT_W-1:0]      wb_count
);
  localparam int LINE_W = ADDR_W - OFF_W;
  fetch_state_t r_state, w_next;
  logic [LINE_W-1:0] r_miss_line;
  logic [TAG_W-1:0]  r_vtag, w_sel_tag;
  logic [CNT_W-1:0]  r_miss_cnt, r_wb_cnt;
  logic              w_accept;
  way_tag_mux #(.WAYS(WAYS), .TAG_W(TAG_W), .WW(WW)) u_way_tag_mux (
    .tags(tags),
    .sel (victim_way),
    .tag (w_sel_tag)
  );
  assign w_accept    = r_state == IDLE && miss_req;
  assign pmem_write  = r_state == WRITEBACK;
  assign pmem_read   = r_state == ALLOCATE;
  assign busy        = r_state != IDLE;
  assign clear_dirty = pmem_write && pmem_resp;
  assign load_line   = pmem_read && pmem_resp;
  assign fill_done   = r_state == DONE;
  assign miss_count  = r_miss_cnt;
  assign wb_count    = r_wb_cnt;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (miss_req) w_next = victim_dirty ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (pmem_resp) w_next = ALLOCATE;
      ALLOCATE:  if (pmem_resp) w_next = DONE;
      DONE:      w_next = IDLE;
    endcase
  end
  // IDLE passes the CPU address straight through; busy states use only latched values
  always_comb begin
    pmem_address = r_state == IDLE      ? {mem_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}}
                 : r_state == WRITEBACK ? line_addr(ADDR_W'(r_vtag), ADDR_W'(r_miss_line[IDX_W-1:0]), IDX_W, OFF_W)
                 :                        {r_miss_line, {OFF_W{1'b0}}};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_miss_line <= '0;
      r_vtag      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_miss_line <= mem_address[ADDR_W-1:OFF_W];
        r_vtag      <= w_sel_tag;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (w_accept && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      if (clear_dirty && !(&r_wb_cnt)) r_wb_cnt <= r_wb_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_cache_line_fetch.sv
// tb_cache_line_fetch: randomized transaction-level check of the line fetch controller
module tb_cache_line_fetch;
  localparam int WAYS = 4, TAG_W = 24, IDX_W = 3, OFF_W = 5, CNT_W = 4, WW = 2;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0, rst_n = 1'b0, miss_req = 1'b0, victim_dirty = 1'b0, pmem_resp = 1'b0;
  logic [31:0] mem_address = '0;
  logic [WW-1:0] victim_way = '0;
  logic [WAYS*TAG_W-1:0] tags = '0;
  logic pmem_read, pmem_write, busy, load_line, clear_dirty, fill_done;
  logic [31:0] pmem_address;
  logic [CNT_W-1:0] miss_count, wb_count;
  int checks = 0, failures = 0, exp_miss = 0, exp_wb = 0;
  cache_line_fetch #(.WAYS(WAYS), .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .mem_address(mem_address),
    .victim_way(victim_way), .victim_dirty(victim_dirty), .tags(tags), .pmem_resp(pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address), .busy(busy),
    .load_line(load_line), .clear_dirty(clear_dirty), .fill_done(fill_done),
    .miss_count(miss_count), .wb_count(wb_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ctl();
    return 32'({busy, pmem_read, pmem_write, load_line, clear_dirty, fill_done});
  endfunction
  function automatic int sat(input int v);
    return v > CMAX ? CMAX : v;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic scramble;
    mem_address  = $urandom;
    tags         = {$urandom, $urandom, $urandom};
    victim_way   = WW'($urandom);
    victim_dirty = 1'($urandom);
    miss_req     = 1'($urandom);
  endtask
  task automatic chk_counts(input string t);
    chk({t, "_miss_cnt"}, 32'(miss_count), 32'(exp_miss));
    chk({t, "_wb_cnt"}, 32'(wb_count), 32'(exp_wb));
  endtask
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      scramble;
      miss_req  = 1'b0;
      pmem_resp = 1'($urandom);
      #3;
      chk("idle_ctl", ctl(), 32'(6'b000000));
      chk("idle_addr", pmem_address, mem_address & ~32'h1F);
      chk_counts("idle");
      step;
    end
  endtask
  task automatic do_miss(input logic [31:0] a, input logic [WW-1:0] w, input logic d,
                         input logic [WAYS*TAG_W-1:0] t, input int l1, input int l2);
    logic [TAG_W-1:0] vt;
    logic [31:0] wb_a, rd_a;
    vt   = t[w*TAG_W +: TAG_W];
    wb_a = (32'(vt) << (IDX_W + OFF_W)) | (a & 32'h0000_00E0);
    rd_a = a & ~32'h1F;
    miss_req = 1'b1; mem_address = a; victim_way = w; victim_dirty = d; tags = t;
    pmem_resp = 1'($urandom);
    #3;
    chk("accept_ctl", ctl(), 32'(6'b000000));
    chk("accept_addr", pmem_address, rd_a);
    exp_miss = sat(exp_miss + 1);
    step;
    if (d) for (int i = 1; i <= l1; i++) begin
      scramble;
      pmem_resp = i == l1;
      #3;
      chk("wb_ctl", ctl(), 32'({4'b1010, pmem_resp, 1'b0}));
      chk("wb_addr", pmem_address, wb_a);
      if (i == l1) exp_wb = sat(exp_wb + 1);
      step;
    end
    for (int i = 1; i <= l2; i++) begin
      scramble;
      pmem_resp = i == l2;
      #3;
      chk("rd_ctl", ctl(), 32'({3'b110, pmem_resp, 2'b00}));
      chk("rd_addr", pmem_address, rd_a);
      step;
    end
    scramble;
    pmem_resp = 1'($urandom);
    #3;
    chk("done_ctl", ctl(), 32'(6'b100001));
    chk_counts("done");
    step;
  endtask
  initial begin
    logic [WAYS*TAG_W-1:0] t;
    mem_address = 32'hDEAD_BEEF;
    #3;
    chk("rst_ctl", ctl(), 32'(6'b000000));
    chk("rst_addr", pmem_address, 32'hDEAD_BEE0);
    chk_counts("rst");
    step;
    step;
    rst_n = 1'b1;
    do_miss(32'h0000_1234, 2'd0, 1'b0, {$urandom, $urandom, $urandom}, 1, 3);
    t = {$urandom, $urandom, $urandom};
    t[2*TAG_W +: TAG_W] = 24'hABCDEF;
    do_miss(32'h1111_10A4, 2'd2, 1'b1, t, 2, 3);
    do_miss(32'h8000_0040, 2'd3, 1'b1, {$urandom, $urandom, $urandom}, 1, 1);
    idle_cycles(3);
    for (int n = 0; n < 40; n++) begin
      idle_cycles($urandom_range(2));
      do_miss($urandom, WW'($urandom), 1'($urandom), {$urandom, $urandom, $urandom},
              $urandom_range(4, 1), $urandom_range(4, 1));
    end
    idle_cycles(2);
    miss_req = 1'b1; victim_dirty = 1'b0; mem_address = 32'h0000_2000; pmem_resp = 1'b0;
    step;
    miss_req = 1'b0;
    step;
    pmem_resp = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", ctl(), 32'(6'b000000));
    chk("midrst_addr", pmem_address, 32'h0000_2000);
    exp_miss = 0;
    exp_wb = 0;
    chk_counts("midrst");
    step;
    pmem_resp = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    idle_cycles(2);
    do_miss(32'h0000_3300, 2'd1, 1'b1, {$urandom, $urandom, $urandom}, 3, 2);
    idle_cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_line_fetch.md
# cache_line_fetch

Parametrised memory-side line controller for the set-associative cache: owns the physical-memory handshake for a miss, writes back a dirty victim from any of WAYS ways, then allocates the missing line. It sits between the cache control FSM/datapath and physical memory. It generates pmem_address from a latched victim tag or miss address, sequences pmem_write/pmem_read against pmem_resp, and keeps saturating miss/writeback counters.

## Interface
- WAYS, 2, associativity; power of two, ≥2
- TAG_W, 24, tag width
- IDX_W, 3, set-index width
- OFF_W, 5, line-offset width; TAG_W+IDX_W+OFF_W must equal 32
- CNT_W, 16, width of each performance counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- miss_req  in  1  cache control requests a line fill; level, sampled in IDLE only
- mem_address  in  32  CPU address of the missing access
- victim_way  in  max(1,$clog2(WAYS))  way chosen for replacement (LRU output)
- victim_dirty  in  1  dirty bit of victim_way in the addressed set
- tags  in  WAYS*TAG_W  packed tag array of the addressed set; way w at [w*TAG_W +: TAG_W]
- pmem_resp  in  1  physical memory completes the current read/write
- pmem_read  out  1  line read request
- pmem_write  out  1  line write request
- pmem_address  out  32  line-aligned physical address
- busy  out  1  high in any state other than IDLE
- load_line  out  1  one-cycle strobe: load pmem_rdata into data array at latched way
- clear_dirty  out  1  one-cycle strobe: clear dirty bit of latched way
- fill_done  out  1  one-cycle strobe: fill complete, cache may re-evaluate hit
- miss_count  out  CNT_W  accepted misses, saturating
- wb_count  out  CNT_W  completed writebacks, saturating

## Operation
- States: IDLE, WRITEBACK, ALLOCATE, DONE.
- IDLE & miss_req: latch mem_address[31:OFF_W] as miss_line, victim_way as way_q, tags[way_q] as vtag_q; increment miss_count. Next = WRITEBACK if victim_dirty, else ALLOCATE.
- WRITEBACK: pmem_write=1, pmem_address={vtag_q, miss_line index, OFF_W'0}. On pmem_resp: clear_dirty=1 that cycle, increment wb_count, next = ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_address={miss_line, OFF_W'0}. On pmem_resp: load_line=1 that cycle, next = DONE.
- DONE: fill_done=1, next = IDLE unconditionally.
- IDLE pmem_address = {mem_address[31:OFF_W], OFF_W'0} (combinational pass-through); pmem_read=pmem_write=0.
- pmem_read and pmem_write are never high together; both are decoded from state only (Moore).
- Inputs changing after acceptance (mem_address, victim_way, tags, victim_dirty) do not affect the in-flight transaction.
- miss_req while busy: ignored, not counted. pmem_resp in IDLE or DONE: ignored.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE; way_q, vtag_q, miss_line, counters = 0; pmem_read, pmem_write, busy, load_line, clear_dirty, fill_done = 0; pmem_address follows mem_address.
- Reset mid-transaction: request lines drop immediately; no strobe is emitted; counters clear.
- Accept at edge N; pmem_* valid from cycle N+1.
- Clean miss with memory latency L cycles (pmem_resp in the L-th request cycle): fill_done in cycle N+L+1, IDLE at N+L+2.
- Dirty miss: writeback L1 cycles then allocate L2 cycles; fill_done in cycle N+L1+L2+1.
- Zero idle cycles between WRITEBACK and ALLOCATE; pmem_address switches in the same edge pmem_write falls.
- Back-to-back: miss_req held high through DONE is accepted again in the first IDLE cycle.

## Structure
- Package cache_fetch_pkg: fetch_state_t enum (IDLE, WRITEBACK, ALLOCATE, DONE); ADDR_W=32 constant; function line_addr(tag, idx) returning {tag, idx, OFF_W'0}.
- Sub-module way_tag_mux: parametrised WAYS:1 selector from the packed tags bus by victim_way; instantiated once before the vtag_q register.
- Counters are one generic saturating always_ff pair, not a sub-module.

## Test plan
- Reset: assert rst_n=0 mid-ALLOCATE -> pmem_read=0 same cycle, state IDLE, miss_count=0, no load_line.
- Clean miss, WAYS=2: mem_address=0x0000_1234, victim_dirty=0, pmem_resp after 3 cycles -> pmem_read with pmem_address=0x0000_1220, one load_line, fill_done at cycle 4 after accept, wb_count=0, miss_count=1.
- Dirty miss, WAYS=4: victim_way=2, tags[2]=0xABCDEF, set 5, mem_address=0x1111_10A4 -> pmem_write to 0xABCD_EFA0, clear_dirty on resp, then pmem_read to 0x1111_10A0, wb_count=1.
- Input stability: change mem_address and tags every cycle after accept -> pmem_address constant through WRITEBACK/ALLOCATE.
- Ignored events: miss_req pulses and spurious pmem_resp during DONE/IDLE -> no extra counts, no strobes, no request lines.
- Saturation, CNT_W=2: 5 clean misses -> miss_count stays 3 after third.
